// File: rtl/nova_io_cpu_intc_if.sv
// Shared Nova I/O bus signals seen by one device block.
// Bit 0 is the most significant bit throughout, matching Nova numbering.
interface nova_io_cpu_intc_if;
   logic        bs_rst;
   logic        bs_stb;
   logic        bs_we;
   logic [0:7]  bs_adr;
   logic [0:15] bs_din;
   logic [0:15] bs_dout;

   modport slave (
      output bs_rst, bs_dout,
      input  bs_stb, bs_we, bs_adr, bs_din
   );

   modport master (
      input  bs_rst, bs_dout,
      output bs_stb, bs_we, bs_adr, bs_din
   );
endinterface

// File: rtl/nova_io_cpu_intc.sv
// CPU pseudo-device for the Nova I/O bus: priority interrupt controller,
// interrupt enable with one-cycle ION delay, INTA code read, IORST pulse and halt.
module nova_io_cpu_intc #(
   parameter logic [5:0]  device_addr   = 6'o77,
   parameter int unsigned num_irq       = 16,
   parameter logic [5:0]  irq_code_base = 6'o10,
   parameter logic [15:0] cpu_id        = 16'h8010,
   parameter int unsigned iorst_cycles  = 4
) (
   input  logic                 pclk,
   input  logic                 prst,
   nova_io_cpu_intc_if.slave    bs,
   input  logic [0:num_irq-1]   irq_req,
   input  logic                 cntrl_intack,
   input  logic                 cntrl_cont,
   output logic                 cntrl_int,
   output logic                 cntrl_halt
);

   localparam int unsigned CNT_W = $clog2(iorst_cycles + 1);

   typedef enum logic [1:0] {
      FN_CTL = 2'b00,
      FN_ID  = 2'b01,
      FN_MSK = 2'b10,
      FN_RST = 2'b11
   } fn_e;

   logic              sel, wr, rd, pend;
   fn_e               fn;
   logic [1:0]        ctl;
   logic [5:0]        code;
   logic              found;

   logic              int_en_q, int_en_d;
   logic              ion_dly_q, ion_dly_d;
   logic [0:15]       mask_q, mask_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              halt_q, halt_d;
   logic              int_q, int_d;
   logic [0:15]       dout_q, dout_d;

   always_comb begin
      sel = bs.bs_stb && (bs.bs_adr[0:5] == device_addr);
      wr  = sel && bs.bs_we;
      rd  = sel && !bs.bs_we;
      fn  = fn_e'(bs.bs_adr[6:7]);
      ctl = bs.bs_din[14:15];
   end

   // Lowest index wins; requests are not latched, so INTA sees this cycle's lines.
   always_comb begin
      code  = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < num_irq; i++) begin
         if (!found && irq_req[i] && !mask_q[i]) begin
            found = 1'b1;
            code  = irq_code_base + 6'(i);
         end
      end
      pend = found;
   end

   always_comb begin
      int_en_d  = int_en_q;
      ion_dly_d = 1'b0;
      mask_d    = mask_q;
      cnt_d     = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
      halt_d    = halt_q;
      int_d     = int_en_q && !ion_dly_q && pend;
      dout_d    = '0;

      // Bus writes are applied after intack/continue so that they take priority.
      if (cntrl_intack) int_en_d = 1'b0;
      if (cntrl_cont)   halt_d   = 1'b0;

      if (wr) begin
         case (fn)
            FN_CTL: begin
               if (ctl == 2'b01) begin
                  int_en_d  = 1'b1;
                  ion_dly_d = 1'b1;
               end else if (ctl == 2'b10) begin
                  int_en_d = 1'b0;
               end
            end
            FN_MSK:  mask_d = bs.bs_din;
            FN_RST:  halt_d = 1'b1;
            default: ;
         endcase
      end

      if (rd) begin
         case (fn)
            FN_CTL: dout_d = {14'b0, int_q, int_en_q};
            FN_ID:  dout_d = cpu_id;
            FN_MSK: dout_d = {10'b0, code};
            FN_RST: begin
               mask_d    = '0;
               int_en_d  = 1'b0;
               ion_dly_d = 1'b0;
               cnt_d     = CNT_W'(iorst_cycles);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge pclk) begin
      if (prst) begin
         int_en_q  <= 1'b0;
         ion_dly_q <= 1'b0;
         mask_q    <= '0;
         cnt_q     <= '0;
         halt_q    <= 1'b0;
         int_q     <= 1'b0;
         dout_q    <= '0;
      end else begin
         int_en_q  <= int_en_d;
         ion_dly_q <= ion_dly_d;
         mask_q    <= mask_d;
         cnt_q     <= cnt_d;
         halt_q    <= halt_d;
         int_q     <= int_d;
         dout_q    <= dout_d;
      end
   end

   assign bs.bs_rst  = prst || (cnt_q != '0);
   assign bs.bs_dout = dout_q;
   assign cntrl_int  = int_q;
   assign cntrl_halt = halt_q;

endmodule

// File: tb/tb_nova_io_cpu_intc.sv
// Bench for nova_io_cpu_intc: directed literal checks plus randomized traffic
// compared every cycle against a timestamp-based behavioural model.
module tb_nova_io_cpu_intc;

   logic        pclk = 1'b0;
   logic        prst = 1'b1;
   logic [0:15] irq_req = '0;
   logic        cntrl_intack = 1'b0;
   logic        cntrl_cont = 1'b0;
   logic        cntrl_int, cntrl_halt;

   int n_cmp = 0;
   int n_fail = 0;

   nova_io_cpu_intc_if bus_if ();

   nova_io_cpu_intc #(
      .device_addr  (6'o77),
      .num_irq      (16),
      .irq_code_base(6'o10),
      .cpu_id       (16'h8010),
      .iorst_cycles (4)
   ) dut (
      .pclk        (pclk),
      .prst        (prst),
      .bs          (bus_if),
      .irq_req     (irq_req),
      .cntrl_intack(cntrl_intack),
      .cntrl_cont  (cntrl_cont),
      .cntrl_int   (cntrl_int),
      .cntrl_halt  (cntrl_halt)
   );

   always #5 pclk = ~pclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: enable flag, edge index of the last ION, mask, halt,
   // edge index until which bus reset is held, and expected registered outputs.
   bit          m_valid = 0;
   bit          m_int_en;
   int          ion_at;
   logic [0:15] m_mask;
   bit          m_halt;
   int          rst_until;
   bit          m_int;
   logic [15:0] m_dout;
   int          edge_n = 0;

   always @(posedge pclk) begin
      automatic int k = edge_n + 1;
      automatic bit sel = bus_if.bs_stb && (bus_if.bs_adr[0:5] == 6'o77);
      automatic bit wr = sel && bus_if.bs_we;
      automatic bit rd = sel && !bus_if.bs_we;
      automatic int fn = int'(bus_if.bs_adr[6:7]);
      automatic int winner = -1;
      automatic bit en_n;
      for (int i = 0; i < 16; i++)
         if (winner < 0 && irq_req[i] && !m_mask[i]) winner = i;
      if (prst) begin
         m_valid   <= 1;
         m_int_en  <= 0;
         ion_at    <= -10;
         m_mask    <= '0;
         m_halt    <= 0;
         rst_until <= k;
         m_int     <= 0;
         m_dout    <= '0;
      end else begin
         m_int <= m_int_en && (k - ion_at >= 2) && (winner >= 0);
         en_n = m_int_en;
         if (rd && fn == 3) en_n = 0;
         else if (wr && fn == 0 && bus_if.bs_din[14:15] == 2'b01) en_n = 1;
         else if (wr && fn == 0 && bus_if.bs_din[14:15] == 2'b10) en_n = 0;
         else if (cntrl_intack) en_n = 0;
         m_int_en <= en_n;
         if (wr && fn == 0 && bus_if.bs_din[14:15] == 2'b01) ion_at <= k;
         if (wr && fn == 2) m_mask <= bus_if.bs_din;
         if (rd && fn == 3) begin
            m_mask    <= '0;
            rst_until <= k + 4;
         end
         if (wr && fn == 3) m_halt <= 1;
         else if (cntrl_cont) m_halt <= 0;
         if (!rd) m_dout <= '0;
         else if (fn == 0) m_dout <= {14'b0, m_int, m_int_en};
         else if (fn == 1) m_dout <= 16'h8010;
         else if (fn == 2) m_dout <= (winner < 0) ? 16'h0000 : 16'((8 + winner) % 64);
         else m_dout <= '0;
      end
      edge_n <= k;
   end

   always @(negedge pclk) begin
      if (m_valid) begin
         chk("model.bs_dout", 32'(bus_if.bs_dout), 32'(m_dout));
         chk("model.cntrl_int", 32'(cntrl_int), 32'(m_int));
         chk("model.cntrl_halt", 32'(cntrl_halt), 32'(m_halt));
         chk("model.bs_rst", 32'(bus_if.bs_rst), 32'(prst || (edge_n < rst_until)));
      end
   end

   task automatic cyc();
      @(negedge pclk);
      #1;
   endtask

   task automatic bus(input logic we, input logic [1:0] fn, input logic [15:0] din,
                      input logic [5:0] dev = 6'o77);
      bus_if.bs_stb = 1'b1;
      bus_if.bs_we  = we;
      bus_if.bs_adr = {dev, fn};
      bus_if.bs_din = din;
      cyc();
      bus_if.bs_stb = 1'b0;
      bus_if.bs_we  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      bus_if.bs_stb = 1'b0;
      bus_if.bs_we  = 1'b0;
      bus_if.bs_adr = '0;
      bus_if.bs_din = '0;

      // Reset
      cyc();
      cyc();
      chk("reset.bs_rst_high", 32'(bus_if.bs_rst), 32'd1);
      prst = 1'b0;
      cyc();
      chk("reset.bs_rst_low", 32'(bus_if.bs_rst), 32'd0);
      chk("reset.dout", 32'(bus_if.bs_dout), 32'h0);
      chk("reset.int", 32'(cntrl_int), 32'd0);
      chk("reset.halt", 32'(cntrl_halt), 32'd0);
      bus(1'b0, 2'b01, 16'h0);
      chk("dia.cpu_id", 32'(bus_if.bs_dout), 32'h8010);

      // ION delay and masking
      irq_req = '0;
      irq_req[3] = 1'b1;
      bus(1'b1, 2'b00, 16'h0001);
      chk("ion.int_t1", 32'(cntrl_int), 32'd0);
      cyc();
      chk("ion.int_t2", 32'(cntrl_int), 32'd0);
      cyc();
      chk("ion.int_t3", 32'(cntrl_int), 32'd1);
      bus(1'b1, 2'b10, 16'h1000);
      cyc();
      chk("msko.int_off", 32'(cntrl_int), 32'd0);

      // INTA priority
      irq_req = '0;
      irq_req[2] = 1'b1;
      irq_req[9] = 1'b1;
      bus(1'b1, 2'b10, 16'h0000);
      bus(1'b0, 2'b10, 16'h0);
      chk("inta.line2", 32'(bus_if.bs_dout), 32'h000A);
      bus(1'b1, 2'b10, 16'h2000);
      bus(1'b0, 2'b10, 16'h0);
      chk("inta.line9", 32'(bus_if.bs_dout), 32'h0011);
      bus(1'b0, 2'b00, 16'h0, 6'o10);
      chk("other_dev.dout", 32'(bus_if.bs_dout), 32'h0);

      // Intack alone, then intack colliding with ION
      cntrl_intack = 1'b1;
      cyc();
      cntrl_intack = 1'b0;
      bus(1'b0, 2'b00, 16'h0);
      chk("intack.status", 32'(bus_if.bs_dout), 32'h0002);
      cntrl_intack = 1'b1;
      bus(1'b1, 2'b00, 16'h0001);
      cntrl_intack = 1'b0;
      chk("collide.int_t1", 32'(cntrl_int), 32'd0);
      cyc();
      chk("collide.int_t2", 32'(cntrl_int), 32'd0);
      bus(1'b0, 2'b00, 16'h0);
      chk("collide.status", 32'(bus_if.bs_dout), 32'h0001);
      chk("collide.int_t4", 32'(cntrl_int), 32'd1);

      // IORST pulse length and state clearing
      bus(1'b1, 2'b10, 16'hFFFF);
      bus(1'b0, 2'b11, 16'h0);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus_if.bs_rst) cnt++;
         cyc();
      end
      chk("iorst.len4", 32'(cnt), 32'd4);
      bus(1'b0, 2'b00, 16'h0);
      chk("iorst.status", 32'(bus_if.bs_dout), 32'h0000);
      bus(1'b0, 2'b10, 16'h0);
      chk("iorst.mask_clear", 32'(bus_if.bs_dout), 32'h000A);
      cnt = 0;
      bus(1'b0, 2'b11, 16'h0);
      if (bus_if.bs_rst) cnt++;
      cyc();
      if (bus_if.bs_rst) cnt++;
      bus(1'b0, 2'b11, 16'h0);
      for (int i = 0; i < 10; i++) begin
         if (bus_if.bs_rst) cnt++;
         cyc();
      end
      chk("iorst.len6", 32'(cnt), 32'd6);

      // Halt and continue
      bus(1'b1, 2'b11, 16'h0);
      chk("halt.set", 32'(cntrl_halt), 32'd1);
      cntrl_cont = 1'b1;
      cyc();
      cntrl_cont = 1'b0;
      chk("halt.cont", 32'(cntrl_halt), 32'd0);
      cntrl_cont = 1'b1;
      bus(1'b1, 2'b11, 16'h0);
      cntrl_cont = 1'b0;
      chk("halt.wins", 32'(cntrl_halt), 32'd1);
      cntrl_cont = 1'b1;
      cyc();
      cntrl_cont = 1'b0;
      bus(1'b1, 2'b11, 16'h0, 6'o12);
      chk("halt.other_dev", 32'(cntrl_halt), 32'd0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [1:0] fn;
         logic       we;
         prst = ($urandom_range(0, 299) == 0);
         we = 1'($urandom);
         fn = 2'($urandom);
         if (!we && fn == 2'b11 && $urandom_range(0, 3) != 0) fn = 2'b10;
         bus_if.bs_stb = ($urandom_range(0, 2) == 0);
         bus_if.bs_we  = we;
         bus_if.bs_adr = {($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'o77, fn};
         bus_if.bs_din = 16'($urandom & $urandom);
         if ($urandom_range(0, 3) == 0) irq_req = 16'($urandom & $urandom & $urandom);
         cntrl_intack = ($urandom_range(0, 7) == 0);
         cntrl_cont   = ($urandom_range(0, 7) == 0);
         cyc();
      end
      prst = 1'b0;
      bus_if.bs_stb = 1'b0;
      cntrl_intack = 1'b0;
      cntrl_cont = 1'b0;
      cyc();
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/nova_io_cpu_intc.md
Name: nova_io_cpu_intc

Overview:
- Parametrised successor to the CPU pseudo-device (code 77) on the Nova I/O bus.
- Adds a real priority interrupt controller: N level-sensitive request lines, an interrupt mask, and interrupt-enable with the one-cycle ION delay.
- Adds an INTA read that returns the device code of the winning request, a multi-cycle IORST pulse, and halt/continue handshaking.
- Sits on the shared bs_* bus beside the other device blocks and drives interrupt and halt control into the CPU core.

Parameters:
- device_addr, 6'o77, bus device code this block decodes.
- num_irq, 16, number of request lines (1..16); line i maps to mask bit i.
- irq_code_base, 6'o10, device code reported for line i is irq_code_base+i (6-bit, wraps mod 64).
- cpu_id, 16'h8010, value returned by DIA (read, adr[6:7]=01).
- iorst_cycles, 4, length in clocks of the bs_rst pulse generated by IORST (>=1).

Ports:
- pclk  in  1  clock, all logic rising-edge.
- prst  in  1  reset, synchronous, active-high.
- bs_rst  out  1  bus reset = prst | IORST pulse.
- bs_stb  in  1  bus strobe, one-cycle access.
- bs_we  in  1  1=write (DOx/NIO), 0=read (DIx).
- bs_adr  in  8  [0:5] device code, [6:7] function.
- bs_din  in  16  write data [0:15].
- bs_dout  out  16  read data, registered.
- irq_req  in  num_irq  level request, index 0 = highest priority.
- cntrl_intack  in  1  core accepted interrupt (1-cycle pulse).
- cntrl_cont  in  1  console continue, clears halt.
- cntrl_int  out  1  interrupt request to core.
- cntrl_halt  out  1  halt request to core.

Behaviour:
- Reset (prst=1): bs_dout=0, cntrl_int=0, cntrl_halt=0, int_en=0, ion_dly=0, mask=0, IORST counter=0; bs_rst=1 combinationally.
- Select: sel = bs_stb & bs_adr[0:5]==device_addr. bs_dout is registered: selected read data appears in the cycle after the strobe. bs_dout=16'h0000 in every other cycle (bus is OR-combined).
- Write, fn 00, by bs_din[14:15]:
  - 01: int_en<=1, ion_dly<=1.
  - 10: int_en<=0.
  - 00 and 11: no effect.
- Write, fn 01: ignored.
- Write, fn 10 (MSKO): mask<=bs_din.
- Write, fn 11: cntrl_halt<=1.
- Read, fn 00: dout={14'b0, cntrl_int, int_en}.
- Read, fn 01: dout=cpu_id.
- Read, fn 10 (INTA): dout={10'b0, code}. code is irq_code_base+i for the lowest-index i with irq_req[i] & ~mask[i]; 0 if none pending. Priority is evaluated on the same-cycle inputs.
- Read, fn 11 (IORST): mask<=0, int_en<=0, ion_dly<=0, counter<=iorst_cycles.
  - bs_rst=1 while counter!=0; counter decrements each clock.
  - A new IORST while counting reloads the counter.
  - cntrl_halt is unaffected.
- pend = |(irq_req & ~mask[0:num_irq-1]), sampled every clock.
- cntrl_int (registered) <= int_en & ~ion_dly & pend. ion_dly clears one clock after being set, so after ION cntrl_int rises no earlier than 2 clocks after the strobe.
- cntrl_intack: int_en<=0. If an ION write occurs in the same cycle, the write wins (int_en=1, ion_dly=1).
- Halt: cntrl_halt is cleared by cntrl_cont. If a halt write and cntrl_cont occur in the same cycle, halt wins.
- A request dropping before INTA gives code 0 if no other line is pending; no latching of requests.
- A strobe to another device code leaves all state unchanged.

Test Plan:
- Reset check: prst 2 clocks -> bs_rst=1 during reset; all outputs 0 after; DIA read returns 16'h8010 one cycle after the strobe.
- Masked request: irq_req[3]=1, ION write (din=16'h0001) -> cntrl_int=1 exactly 2 clocks after the strobe. Then MSKO din=16'h1000 (mask bit 3) -> cntrl_int=0 next clock.
- Priority: irq_req[2] and irq_req[9] high, mask=0 -> INTA read returns 16'h000A (6'o12). Then mask bit 2 -> INTA returns 16'h0011 (6'o21).
- Intack vs ION collision: cntrl_intack and ION write in the same cycle -> int_en read as 1; cntrl_int held low for the one delay cycle.
- IORST: read fn 11 with mask=16'hFFFF, int_en=1 -> bs_rst high exactly 4 clocks; mask=0, int_en=0. A second IORST on clock 2 extends the pulse to 6 clocks total.
- Halt: write fn 11 -> cntrl_halt=1 next clock. cntrl_cont pulse -> 0. Halt write coincident with cntrl_cont -> remains 1.
